// File: rtl/host_msg_pkg.sv
// Shared types and constants for the host message writer and its request FIFO.
package host_msg_pkg;

  localparam int MSG_ID_W   = 16;
  localparam int MSG_DATA_W = 16;

  typedef struct packed {
    logic [MSG_ID_W-1:0]   id;
    logic [MSG_DATA_W-1:0] data;
  } host_msg_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_B,
    RESP
  } state_t;

  localparam logic [1:0] NASTI_BURST_INCR = 2'b01;
  localparam logic [1:0] NASTI_RESP_OKAY  = 2'b00;

  function automatic logic [2:0] nasti_size(input int bytes);
    logic [2:0] code;
    code = 3'($clog2(bytes));
    return code;
  endfunction

endpackage

// File: rtl/nasti_channel.sv
// NASTI (AXI4-style) channel bundle; master drives AW/W/AR and the B/R ready lines.
interface nasti_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);

  logic                    aw_valid, aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [USER_WIDTH-1:0]   aw_user;

  logic                    w_valid, w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [ID_WIDTH-1:0]     w_id;
  logic [USER_WIDTH-1:0]   w_user;

  logic                    b_valid, b_ready;
  logic [1:0]              b_resp;
  logic [ID_WIDTH-1:0]     b_id;
  logic [USER_WIDTH-1:0]   b_user;

  logic                    ar_valid, ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [USER_WIDTH-1:0]   ar_user;

  logic                    r_valid, r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [ID_WIDTH-1:0]     r_id;
  logic [USER_WIDTH-1:0]   r_user;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_id, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_id, w_user,
    input  w_ready,
    input  b_valid, b_resp, b_id, b_user,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_id, ar_user,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_id, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_id, w_user,
    output w_ready,
    output b_valid, b_resp, b_id, b_user,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_id, ar_user,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id, r_user,
    input  r_ready
  );

endinterface

// File: rtl/host_msg_fifo.sv
// Synchronous request FIFO of host messages; full/empty come from the extra pointer MSB.
module host_msg_fifo
  import host_msg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      push,
  input  host_msg_t push_msg,
  output logic      full,
  input  logic      pop,
  output host_msg_t pop_msg,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  host_msg_t      mem [DEPTH];
  logic [PW:0]    wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // A push while full only lands when the same edge frees the head slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign pop_msg = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_msg;
  end

endmodule

// File: rtl/host_msg_writer.sv
// NASTI write initiator: queues {id,data} host messages and writes them one at a time
// to BASE_ADDR, returning each B response on the resp port.
module host_msg_writer
  import host_msg_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 1,
  parameter int                    USER_WIDTH = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ID_WIDTH-1:0]   AXI_ID     = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [MSG_ID_W-1:0]   req_id,
  input  logic [MSG_DATA_W-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_err,
  output logic [MSG_ID_W-1:0]   resp_id,
  nasti_channel.master          nasti
);

  localparam logic [2:0] AW_SIZE = nasti_size(DATA_WIDTH / 8);

  state_t    state, next_state;
  host_msg_t req_msg, head, hold;
  logic      full, empty, live, push, pop;
  logic      aw_valid, w_valid, b_ready;
  logic      aw_done, w_done, aw_fire, w_fire, b_fire;

  // req_ready stays low through reset and the first edge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) live <= 1'b0;
    else       live <= 1'b1;
  end

  assign req_ready = live && !full;
  assign push      = req_valid && req_ready;
  assign req_msg   = '{id: req_id, data: req_data};

  host_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_msg (req_msg),
    .full     (full),
    .pop      (pop),
    .pop_msg  (head),
    .empty    (empty)
  );

  assign aw_fire = aw_valid && nasti.aw_ready;
  assign w_fire  = w_valid && nasti.w_ready;
  assign b_fire  = b_ready && nasti.b_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!empty) next_state = SEND;
      SEND:    if ((aw_done || aw_fire) && (w_done || w_fire)) next_state = WAIT_B;
      WAIT_B:  if (b_fire) next_state = RESP;
      RESP:    if (resp_ready) next_state = empty ? IDLE : SEND;
      default: next_state = IDLE;
    endcase
  end

  // AW and W are offered together and retire independently.
  always_comb begin
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;
    resp_valid = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE:   pop = !empty;
      SEND: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
      end
      WAIT_B: b_ready = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
        pop        = resp_ready && !empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != SEND) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    hold <= '0;
    else if (pop) hold <= head;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_err <= 1'b0;
      resp_id  <= '0;
    end else if (b_fire) begin
      resp_err <= (nasti.b_resp != NASTI_RESP_OKAY);
      resp_id  <= hold.id;
    end
  end

  assign nasti.aw_valid  = aw_valid;
  assign nasti.aw_addr   = BASE_ADDR;
  assign nasti.aw_len    = 8'd0;
  assign nasti.aw_size   = AW_SIZE;
  assign nasti.aw_burst  = NASTI_BURST_INCR;
  assign nasti.aw_lock   = 1'b0;
  assign nasti.aw_cache  = 4'd0;
  assign nasti.aw_prot   = 3'd0;
  assign nasti.aw_qos    = 4'd0;
  assign nasti.aw_region = 4'd0;
  assign nasti.aw_id     = AXI_ID;
  assign nasti.aw_user   = '0;

  assign nasti.w_valid   = w_valid;
  assign nasti.w_data    = DATA_WIDTH'(hold);
  assign nasti.w_strb    = '1;
  assign nasti.w_last    = 1'b1;
  assign nasti.w_id      = AXI_ID;
  assign nasti.w_user    = '0;

  assign nasti.b_ready   = b_ready;

  assign nasti.ar_valid  = 1'b0;
  assign nasti.ar_addr   = '0;
  assign nasti.ar_len    = 8'd0;
  assign nasti.ar_size   = 3'd0;
  assign nasti.ar_burst  = 2'd0;
  assign nasti.ar_lock   = 1'b0;
  assign nasti.ar_cache  = 4'd0;
  assign nasti.ar_prot   = 3'd0;
  assign nasti.ar_qos    = 4'd0;
  assign nasti.ar_region = 4'd0;
  assign nasti.ar_id     = '0;
  assign nasti.ar_user   = '0;
  assign nasti.r_ready   = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{nasti.b_id, nasti.b_user, nasti.ar_ready, nasti.r_valid,
                           nasti.r_data, nasti.r_resp, nasti.r_last, nasti.r_id, nasti.r_user};

endmodule
